// File: rtl/stt_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stt_pkg : shared types, default sizes and the ROB-age compare for STT rename
// Revision: 1.0
// ----------------------------------------------------------------------------
package stt_pkg;

  localparam int NUM_DECODE_DEF = 4;
  localparam int NUM_ARCH_DEF   = 32;
  localparam int NUM_PHY_DEF    = 128;
  localparam int NUM_ROB_DEF    = 64;
  localparam int NUM_CKPT_DEF   = 4;

  localparam int ARCH_W = $clog2(NUM_ARCH_DEF);
  localparam int PHY_W  = $clog2(NUM_PHY_DEF);
  localparam int ROB_W  = $clog2(NUM_ROB_DEF);
  localparam int CKPT_W = $clog2(NUM_CKPT_DEF);

  typedef enum logic [1:0] {
    INST_ALU    = 2'b00,
    INST_LOAD   = 2'b01,
    INST_BRANCH = 2'b10,
    INST_NOP    = 2'b11
  } inst_type_e;

  typedef struct packed {
    logic             wrap;
    logic [ROB_W-1:0] idx;
  } rob_id_t;

  typedef struct packed {
    logic    valid;
    rob_id_t id;
  } yrot_t;

  // Wrap bit disambiguates the two laps of the circular ROB index.
  function automatic logic is_younger(input rob_id_t a, input rob_id_t b);
    return (a.wrap == b.wrap) ? (a.idx > b.idx) : (a.idx < b.idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stt_ckpt_ring.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stt_ckpt_ring : FIFO ring of RAT+YRoT snapshots with push/pop/restore
// Revision: 1.0
// ----------------------------------------------------------------------------
module stt_ckpt_ring
  import stt_pkg::*;
#(
  parameter int NUM_CKPT   = NUM_CKPT_DEF,
  parameter int RAT_BITS   = NUM_ARCH_DEF * PHY_W,
  parameter int YTAB_BITS  = NUM_ARCH_DEF * (ROB_W + 2),
  parameter int CKPT_WIDTH = $clog2(NUM_CKPT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [RAT_BITS-1:0]   push_rat,
  input  logic [YTAB_BITS-1:0]  push_ytab,
  input  logic                  pop,
  input  logic                  restore,
  input  logic [CKPT_WIDTH-1:0] restore_idx,
  output logic [RAT_BITS-1:0]   restore_rat,
  output logic [YTAB_BITS-1:0]  restore_ytab,
  output logic [CKPT_WIDTH-1:0] tail,
  output logic [CKPT_WIDTH:0]   count
);

  localparam logic [CKPT_WIDTH:0] DEPTH = (CKPT_WIDTH + 1)'(NUM_CKPT);

  logic [RAT_BITS-1:0]   snap_rat  [NUM_CKPT];
  logic [YTAB_BITS-1:0]  snap_ytab [NUM_CKPT];
  logic [CKPT_WIDTH-1:0] head;
  logic                  do_pop;
  logic [CKPT_WIDTH:0]   kept;

  function automatic logic [CKPT_WIDTH-1:0] ring_inc(input logic [CKPT_WIDTH-1:0] x);
    return (x == CKPT_WIDTH'(NUM_CKPT - 1)) ? '0 : x + 1'b1;
  endfunction

  assign do_pop       = pop && (count != '0);
  assign restore_rat  = snap_rat[restore_idx];
  assign restore_ytab = snap_ytab[restore_idx];

  // Entries from head up to and including the restored one survive a squash.
  always_comb begin
    if (restore_idx >= head) begin
      kept = {1'b0, restore_idx - head} + 1'b1;
    end else begin
      kept = {1'b0, restore_idx} + DEPTH - {1'b0, head} + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_pop) begin
        head <= ring_inc(head);
      end
      if (restore) begin
        tail  <= ring_inc(restore_idx);
        count <= do_pop ? kept - 1'b1 : kept;
      end else begin
        if (push) begin
          tail <= ring_inc(tail);
        end
        case ({push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      snap_rat[tail]  <= push_rat;
      snap_ytab[tail] <= push_ytab;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stt_rename_ckpt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stt_rename_ckpt : STT rename + YRoT tracking with branch checkpoint recovery
// Revision: 1.0
// ----------------------------------------------------------------------------
module stt_rename_ckpt
  import stt_pkg::*;
#(
  parameter int NUM_DECODE = NUM_DECODE_DEF,
  parameter int NUM_ARCH   = NUM_ARCH_DEF,
  parameter int NUM_PHY    = NUM_PHY_DEF,
  parameter int NUM_ROB    = NUM_ROB_DEF,
  parameter int NUM_CKPT   = NUM_CKPT_DEF,
  localparam int ARCH_WIDTH = $clog2(NUM_ARCH),
  localparam int PHY_WIDTH  = $clog2(NUM_PHY),
  localparam int YROT_WIDTH = $clog2(NUM_ROB),
  localparam int CKPT_WIDTH = $clog2(NUM_CKPT)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [(2+3*ARCH_WIDTH)*NUM_DECODE-1:0] insts_flatten,
  input  logic [PHY_WIDTH*NUM_DECODE-1:0]       phyreg_flatten,
  input  logic [YROT_WIDTH:0]                   rob_tail,
  input  logic [YROT_WIDTH:0]                   vis_point,
  input  logic                                  squash_valid,
  input  logic [CKPT_WIDTH-1:0]                 squash_ckpt,
  input  logic                                  resolve_valid,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [3*PHY_WIDTH*NUM_DECODE-1:0]     out_insts_flatten,
  output logic [(YROT_WIDTH+2)*NUM_DECODE-1:0]  younger_outputs_flatten,
  output logic [CKPT_WIDTH-1:0]                 out_ckpt,
  output logic                                  ckpt_overflow
);

  localparam int SLOT_WIDTH = 2 + 3 * ARCH_WIDTH;
  localparam int YE_WIDTH   = YROT_WIDTH + 2;
  localparam int OUT_WIDTH  = 3 * PHY_WIDTH;
  localparam logic [CKPT_WIDTH:0] CKPT_FULL = (CKPT_WIDTH + 1)'(NUM_CKPT);

  logic [NUM_ARCH-1:0][PHY_WIDTH-1:0] rat, rat_next, snap_rat;
  yrot_t [NUM_ARCH-1:0]               ytab, ytab_next, snap_ytab;
  logic [NUM_ARCH-1:0][PHY_WIDTH-1:0] restore_rat;
  yrot_t [NUM_ARCH-1:0]               restore_ytab;

  logic [3*PHY_WIDTH*NUM_DECODE-1:0] out_insts_next;
  logic [YE_WIDTH*NUM_DECODE-1:0]    younger_next;
  logic                              has_branch;
  logic                              extra_branch;
  logic                              accept;
  logic [CKPT_WIDTH-1:0]             ring_tail;
  logic [CKPT_WIDTH:0]               ring_count;

  // Slots are renamed in program order against a running copy of the tables,
  // which gives intra-group bypass and youngest-wins writes for free.
  always_comb begin
    logic [SLOT_WIDTH-1:0] slot;
    inst_type_e            itype;
    logic [ARCH_WIDTH-1:0] dest, src1, src2;
    logic [PHY_WIDTH-1:0]  pnew, pdest, ps1, ps2;
    yrot_t                 y1, y2, res;
    logic                  e1, e2;
    rob_id_t               rob_id;
    rob_id_t               vis;

    rat_next       = rat;
    ytab_next      = ytab;
    snap_rat       = rat;
    snap_ytab      = ytab;
    has_branch     = 1'b0;
    extra_branch   = 1'b0;
    out_insts_next = '0;
    younger_next   = '0;
    slot   = '0;
    itype  = INST_NOP;
    dest   = '0;
    src1   = '0;
    src2   = '0;
    pnew   = '0;
    pdest  = '0;
    ps1    = '0;
    ps2    = '0;
    y1     = '0;
    y2     = '0;
    res    = '0;
    e1     = 1'b0;
    e2     = 1'b0;
    rob_id = '0;
    vis    = rob_id_t'(vis_point);

    for (int k = 0; k < NUM_DECODE; k++) begin
      slot   = insts_flatten[(NUM_DECODE-1-k)*SLOT_WIDTH +: SLOT_WIDTH];
      itype  = inst_type_e'(slot[SLOT_WIDTH-1 -: 2]);
      dest   = slot[3*ARCH_WIDTH-1 -: ARCH_WIDTH];
      src1   = slot[2*ARCH_WIDTH-1 -: ARCH_WIDTH];
      src2   = slot[ARCH_WIDTH-1:0];
      pnew   = phyreg_flatten[(NUM_DECODE-1-k)*PHY_WIDTH +: PHY_WIDTH];
      rob_id = rob_id_t'(rob_tail + (YROT_WIDTH + 1)'(k));

      ps1 = rat_next[src1];
      ps2 = rat_next[src2];
      y1  = ytab_next[src1];
      y2  = ytab_next[src2];
      e1  = y1.valid && !is_younger(vis, y1.id);
      e2  = y2.valid && !is_younger(vis, y2.id);

      res   = '0;
      pdest = '0;
      case (itype)
        INST_LOAD: begin
          res   = '{valid: 1'b1, id: rob_id};
          pdest = pnew;
        end
        INST_ALU, INST_BRANCH: begin
          if (e1 && e2) begin
            res = is_younger(y1.id, y2.id) ? y1 : y2;
          end else if (e1) begin
            res = y1;
          end else if (e2) begin
            res = y2;
          end
          if (itype == INST_ALU) begin
            pdest = pnew;
          end
        end
        default: begin
          ps1 = '0;
          ps2 = '0;
        end
      endcase

      if (itype == INST_ALU || itype == INST_LOAD) begin
        rat_next[dest]  = pnew;
        ytab_next[dest] = res;
      end

      if (itype == INST_BRANCH) begin
        if (!has_branch) begin
          snap_rat   = rat_next;
          snap_ytab  = ytab_next;
          has_branch = 1'b1;
        end else begin
          extra_branch = 1'b1;
        end
      end

      out_insts_next[(NUM_DECODE-1-k)*OUT_WIDTH +: OUT_WIDTH] = {pdest, ps1, ps2};
      younger_next[(NUM_DECODE-1-k)*YE_WIDTH +: YE_WIDTH]     = res;
    end
  end

  // A full ring stalls every group so a later branch never finds it full.
  assign in_ready = (!out_valid || out_ready) && !squash_valid && (ring_count < CKPT_FULL);
  assign accept   = in_valid && in_ready;

  stt_ckpt_ring #(
    .NUM_CKPT  (NUM_CKPT),
    .RAT_BITS  (NUM_ARCH * PHY_WIDTH),
    .YTAB_BITS (NUM_ARCH * YE_WIDTH),
    .CKPT_WIDTH(CKPT_WIDTH)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .push        (accept && has_branch),
    .push_rat    (snap_rat),
    .push_ytab   (snap_ytab),
    .pop         (resolve_valid),
    .restore     (squash_valid),
    .restore_idx (squash_ckpt),
    .restore_rat (restore_rat),
    .restore_ytab(restore_ytab),
    .tail        (ring_tail),
    .count       (ring_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        rat[i] <= PHY_WIDTH'(i);
      end
      ytab                    <= '0;
      out_valid               <= 1'b0;
      out_insts_flatten       <= '0;
      younger_outputs_flatten <= '0;
      out_ckpt                <= '0;
      ckpt_overflow           <= 1'b0;
    end else if (squash_valid) begin
      rat       <= restore_rat;
      ytab      <= restore_ytab;
      out_valid <= 1'b0;
    end else if (accept) begin
      rat                     <= rat_next;
      ytab                    <= ytab_next;
      out_valid               <= 1'b1;
      out_insts_flatten       <= out_insts_next;
      younger_outputs_flatten <= younger_next;
      out_ckpt                <= has_branch ? ring_tail : '0;
      if (extra_branch) begin
        ckpt_overflow <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/stt_rename_ckpt.md
# stt_rename_ckpt

Parametrised STT rename stage with branch-checkpoint recovery and a valid/ready handshake. Each cycle it renames a decode group of NUM_DECODE instructions and computes each instruction's YRoT (youngest root of taint, a {wrap, ROB index} pair). It keeps both the RAT and the YRoT table in state. Every branch snapshots RAT+YRoT into a ring of NUM_CKPT checkpoints, so a squash restores the speculative state in one cycle. The block sits between decode and dispatch, replacing the single-shot stt_age rename path.

## Interface
- NUM_DECODE, 4, instructions per group
- NUM_ARCH, 32, architectural registers
- NUM_PHY, 128, physical registers
- NUM_ROB, 64, ROB entries (power of 2)
- NUM_CKPT, 4, checkpoint ring depth
- ARCH_WIDTH / PHY_WIDTH / YROT_WIDTH / CKPT_WIDTH, derived, $clog2 of NUM_ARCH / NUM_PHY / NUM_ROB / NUM_CKPT
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  decode group present
- in_ready  out  1  group accepted when in_valid & in_ready at posedge
- insts_flatten  in  (2+3*ARCH_WIDTH)*NUM_DECODE  per slot {type[1:0], dest, src1, src2}; slot 0 in MSBs and oldest. Type encoding: 00 ALU, 01 load, 10 branch, 11 nop.
- phyreg_flatten  in  PHY_WIDTH*NUM_DECODE  free physical register per slot
- rob_tail  in  YROT_WIDTH+1  {wrap, idx} ROB id of slot 0; slot k gets rob_tail+k, wrapping with wrap-bit toggle
- vis_point  in  YROT_WIDTH+1  {wrap, idx} of oldest unresolved branch
- squash_valid  in  1  restore from checkpoint squash_ckpt
- squash_ckpt  in  CKPT_WIDTH  checkpoint index to restore
- resolve_valid  in  1  oldest checkpoint released
- out_valid  out  1  renamed group valid
- out_ready  in  1  dispatch accepts output
- out_insts_flatten  out  3*PHY_WIDTH*NUM_DECODE  {pdest, psrc1, psrc2} per slot
- younger_outputs_flatten  out  (YROT_WIDTH+2)*NUM_DECODE  {tainted, wrap, idx} per slot
- out_ckpt  out  CKPT_WIDTH  checkpoint allocated by the group's branch (0 if none)
- ckpt_overflow  out  1  sticky; set when a group carries more than one branch

## Operation
- Age compare: a is younger than b iff (a.wrap==b.wrap) ? a.idx>b.idx : a.idx<b.idx.
- YRoT entry format is {valid, wrap, idx}. An entry is effective only when valid and not older than vis_point; otherwise it is untainted.
- Source lookup for slot k:
  - If an older slot j<k in the same group writes that arch reg, use the youngest such j (its pdest and its computed YRoT).
  - Otherwise use RAT/YRoT.
- YRoT result per slot:
  - load: own ROB id, tainted=1.
  - ALU/branch: the younger of the two effective source YRoTs; tainted=0 and value 0 if neither is effective.
  - nop: all zero.
- Dest write: ALU and load write RAT[dest]=phyreg[k] and YRoT[dest]=result. Branch and nop write nothing and output pdest=0. Same-group writes resolve youngest-wins.
- Checkpoint:
  - A branch in slot b pushes a snapshot at ring tail. The snapshot is RAT+YRoT after slots 0..b.
  - The branch's index is reported on out_ckpt.
  - Only the first branch in a group is checkpointed; a later one sets ckpt_overflow.
- Ring is FIFO:
  - resolve pops head.
  - squash restores RAT/YRoT from squash_ckpt, sets tail=squash_ckpt+1, and recomputes count.
- in_ready = (!out_valid | out_ready) & !squash_valid & (count<NUM_CKPT). Ring fullness blocks every group, branch or not.

## Timing
- Rename latency is one cycle: a group accepted at edge N appears on outputs after edge N. RAT/YRoT updates commit at the same edge, so back-to-back groups see them.
- Output register holds while out_valid & !out_ready.
- Squash at edge N:
  - state restored and out_valid cleared after N;
  - any input presented in that cycle is dropped;
  - earliest new accept is edge N+1.
- Squash and resolve in the same cycle both apply. They never target the same entry (upstream guarantee).
- Resolve with an empty ring is ignored.
- Reset (async, any time): RAT[i]=i, all YRoT invalid, ring empty, out_valid=0, all outputs 0, ckpt_overflow=0.

## Structure
- Package stt_pkg holds: the type encodings, the {valid, wrap, idx} YRoT struct, the age-compare function, and derived-width localparams.
- Sub-module stt_ckpt_ring holds NUM_CKPT RAT+YRoT snapshots with head/tail/count, push/pop/restore. The top holds rename, bypass and handshake logic.

## Test plan
- After reset, group of 4 ALU ops (dest 1..4, src 0/0), phyreg 40..43, rob_tail 0 -> psrcs 0, pdest 40..43, all untainted; next group src1=3 -> psrc1=42.
- Intra-group chain, slot0 load r5 (rob 10), slot1 ALU r6=r5+r0 -> slot1 psrc1=slot0 pdest, yrot {1, 0, 10}; vis_point {0, 11} -> next group reading r6 untainted.
- Wrap: rob_tail {0, 62}, loads in all slots -> yrots {0,62}, {0,63}, {1,0}, {1,1}; an ALU reading slot1 and slot3 picks {1,1}.
- Branch in slot 1, then squash to its checkpoint -> RAT/YRoT equal the post-slot-1 state, out_valid=0, input in that cycle dropped.
- Fill 4 checkpoints -> in_ready=0; resolve -> in_ready=1 next cycle; out_ready=0 holds outputs stable.
- Assert rst mid-stream with out_valid=1 -> all outputs 0 immediately, RAT identity after release.
